// File: rtl/cpu_pkg.sv
// Shared CPU definitions: PC source encodings, fixed vectors and helpers
// used by the fetch stage.
package cpu_pkg;

   typedef enum logic [2:0] {
      PCSRC_SEQ = 3'd0,
      PCSRC_BR  = 3'd1,
      PCSRC_J   = 3'd2,
      PCSRC_JR  = 3'd3
   } pcsrc_e;

   localparam logic [31:0] RESET_PC   = 32'h8000_0000;
   localparam logic [31:0] ILLOP_ADDR = 32'h8000_0004;
   localparam logic [31:0] XADR       = 32'h8000_0008;
   localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;

   // Instruction addresses are word aligned; stray low bits are dropped.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-PC priority mux; also qualifies the interrupt request
// and produces the EPC write enable/value.
module next_pc_sel
   import cpu_pkg::*;
(
   input  logic        reset_n_i,
   input  logic [31:0] pc_i,
   input  logic [31:0] id_pc_plus4_i,
   input  logic        pc_hold_i,
   input  logic        ex_br_taken_i,
   input  logic [31:0] ex_br_target_i,
   input  logic        undefine_i,
   input  logic        irq_i,
   input  logic [2:0]  id_pcsrc_i,
   input  logic [31:0] id_jump_target_i,
   input  logic [31:0] id_jr_target_i,
   output logic [31:0] pc_plus4_o,
   output logic [31:0] next_pc_o,
   output logic        epc_we_o,
   output logic [31:0] epc_wdata_o,
   output logic        irq_take_o
);

   logic id_jump;
   logic id_jr;
   logic irq_take;

   assign id_jump = (id_pcsrc_i == PCSRC_J);
   assign id_jr   = (id_pcsrc_i == PCSRC_JR);

   // Interrupts are only taken from user code, and only when nothing of
   // higher priority is redirecting fetch; a deferred Irq simply stays pending.
   assign irq_take = reset_n_i & irq_i & ~pc_i[31] & ~id_pc_plus4_i[31]
                   & ~pc_hold_i & ~ex_br_taken_i & ~undefine_i
                   & ~id_jump & ~id_jr;

   assign irq_take_o = irq_take;
   assign pc_plus4_o = pc_i + 32'd4;

   always_comb begin
      next_pc_o   = pc_plus4_o;
      epc_we_o    = 1'b0;
      epc_wdata_o = pc_i;
      if (pc_hold_i) begin
         next_pc_o = pc_i;
      end else if (ex_br_taken_i) begin
         next_pc_o = word_align(ex_br_target_i);
      end else if (undefine_i) begin
         next_pc_o   = ILLOP_ADDR;
         epc_we_o    = 1'b1;
         epc_wdata_o = id_pc_plus4_i;
      end else if (irq_take) begin
         next_pc_o   = XADR;
         epc_we_o    = 1'b1;
         epc_wdata_o = pc_i;
      end else if (id_jump) begin
         next_pc_o = word_align(id_jump_target_i);
      end else if (id_jr) begin
         next_pc_o = word_align(id_jr_target_i);
      end
   end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register and EPC,
// sequenced by hazard hold/flush and the branch/jump/exception redirects.
module if_stage
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        PC_Hold,
   input  logic        IF_Hold,
   input  logic        IF_Flush,
   input  logic [2:0]  ID_PCSrc,
   input  logic [31:0] ID_JumpTarget,
   input  logic [31:0] ID_JrTarget,
   input  logic        EX_BranchTaken,
   input  logic [31:0] EX_BranchTarget,
   input  logic        Undefine,
   input  logic        Irq,
   input  logic [31:0] IMem_Data,
   output logic [31:0] IMem_Addr,
   output logic        IRQ_Take,
   output logic [31:0] ID_Instr,
   output logic [31:0] ID_PC_Plus4,
   output logic        ID_Valid,
   output logic [31:0] EPC
);

   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc4_q, pc4_d;
   logic        valid_q, valid_d;
   logic [31:0] epc_q, epc_d;
   logic [31:0] pc_plus4;
   logic        epc_we;
   logic [31:0] epc_wdata;

   next_pc_sel u_next_pc_sel (
      .reset_n_i        (reset),
      .pc_i             (pc_q),
      .id_pc_plus4_i    (pc4_q),
      .pc_hold_i        (PC_Hold),
      .ex_br_taken_i    (EX_BranchTaken),
      .ex_br_target_i   (EX_BranchTarget),
      .undefine_i       (Undefine),
      .irq_i            (Irq),
      .id_pcsrc_i       (ID_PCSrc),
      .id_jump_target_i (ID_JumpTarget),
      .id_jr_target_i   (ID_JrTarget),
      .pc_plus4_o       (pc_plus4),
      .next_pc_o        (pc_d),
      .epc_we_o         (epc_we),
      .epc_wdata_o      (epc_wdata),
      .irq_take_o       (IRQ_Take)
   );

   // Flush beats hold so a killed instruction never lingers in ID.
   always_comb begin
      instr_d = instr_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
      epc_d   = epc_we ? epc_wdata : epc_q;
      if (IF_Flush) begin
         instr_d = NOP_INSTR;
         pc4_d   = pc_plus4;
         valid_d = 1'b0;
      end else if (!IF_Hold) begin
         instr_d = IMem_Data;
         pc4_d   = pc_plus4;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q    <= RESET_PC;
         instr_q <= NOP_INSTR;
         pc4_q   <= RESET_PC;
         valid_q <= 1'b0;
         epc_q   <= 32'h0;
      end else begin
         pc_q    <= pc_d;
         instr_q <= instr_d;
         pc4_q   <= pc4_d;
         valid_q <= valid_d;
         epc_q   <= epc_d;
      end
   end

   assign IMem_Addr   = pc_q;
   assign ID_Instr    = instr_q;
   assign ID_PC_Plus4 = pc4_q;
   assign ID_Valid    = valid_q;
   assign EPC         = epc_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed vector table for the fetch scenarios, then
// randomized cycles checked against a behavioural fetch model.
module tb_if_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        PC_Hold, IF_Hold, IF_Flush;
   logic [2:0]  ID_PCSrc;
   logic [31:0] ID_JumpTarget, ID_JrTarget;
   logic        EX_BranchTaken;
   logic [31:0] EX_BranchTarget;
   logic        Undefine, Irq;
   logic [31:0] IMem_Data;
   logic [31:0] IMem_Addr;
   logic        IRQ_Take;
   logic [31:0] ID_Instr, ID_PC_Plus4;
   logic        ID_Valid;
   logic [31:0] EPC;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   if_stage dut (
      .clk             (clk),
      .reset           (reset),
      .PC_Hold         (PC_Hold),
      .IF_Hold         (IF_Hold),
      .IF_Flush        (IF_Flush),
      .ID_PCSrc        (ID_PCSrc),
      .ID_JumpTarget   (ID_JumpTarget),
      .ID_JrTarget     (ID_JrTarget),
      .EX_BranchTaken  (EX_BranchTaken),
      .EX_BranchTarget (EX_BranchTarget),
      .Undefine        (Undefine),
      .Irq             (Irq),
      .IMem_Data       (IMem_Data),
      .IMem_Addr       (IMem_Addr),
      .IRQ_Take        (IRQ_Take),
      .ID_Instr        (ID_Instr),
      .ID_PC_Plus4     (ID_PC_Plus4),
      .ID_Valid        (ID_Valid),
      .EPC             (EPC)
   );

   typedef struct {
      logic        ph, ih, fl;
      logic [2:0]  src;
      logic [31:0] jt, jr;
      logic        br;
      logic [31:0] bt;
      logic        und, irq;
      logic [31:0] imem;
      logic        e_irq;
      logic [31:0] e_pc, e_pc4, e_instr;
      logic        e_valid;
      logic [31:0] e_epc;
   } vec_t;

   vec_t tbl[20];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic ph, ih, fl, input logic [2:0] src,
                               input logic [31:0] jt, jr, input logic br,
                               input logic [31:0] bt, input logic und, irq,
                               input logic [31:0] imem, input logic e_irq,
                               input logic [31:0] e_pc, e_pc4, e_instr,
                               input logic e_valid, input logic [31:0] e_epc);
      vec_t v;
      v.ph = ph; v.ih = ih; v.fl = fl; v.src = src; v.jt = jt; v.jr = jr;
      v.br = br; v.bt = bt; v.und = und; v.irq = irq; v.imem = imem;
      v.e_irq = e_irq; v.e_pc = e_pc; v.e_pc4 = e_pc4; v.e_instr = e_instr;
      v.e_valid = e_valid; v.e_epc = e_epc;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      PC_Hold = v.ph; IF_Hold = v.ih; IF_Flush = v.fl; ID_PCSrc = v.src;
      ID_JumpTarget = v.jt; ID_JrTarget = v.jr; EX_BranchTaken = v.br;
      EX_BranchTarget = v.bt; Undefine = v.und; Irq = v.irq; IMem_Data = v.imem;
   endtask

   // Behavioural model state
   logic [31:0] m_pc, m_pc4, m_instr, m_epc;
   logic        m_valid;

   task automatic model_reset();
      m_pc = 32'h8000_0000; m_pc4 = 32'h8000_0000; m_instr = 32'h0;
      m_valid = 1'b0; m_epc = 32'h0;
   endtask

   function automatic logic model_irq(input vec_t v);
      logic redirect_id;
      redirect_id = (v.src == 3'd2) || (v.src == 3'd3);
      return v.irq && !m_pc[31] && !m_pc4[31] && !v.ph && !v.br && !v.und && !redirect_id;
   endfunction

   task automatic model_step(input vec_t v);
      logic [31:0] npc, nepc;
      logic        take;
      take = model_irq(v);
      nepc = m_epc;
      if (v.ph)                   npc = m_pc;
      else if (v.br)              npc = v.bt & ~32'd3;
      else if (v.und) begin       npc = 32'h8000_0004; nepc = m_pc4; end
      else if (take) begin        npc = 32'h8000_0008; nepc = m_pc;  end
      else if (v.src == 3'd2)     npc = v.jt & ~32'd3;
      else if (v.src == 3'd3)     npc = v.jr & ~32'd3;
      else                        npc = m_pc + 32'd4;
      if (v.fl) begin
         m_instr = 32'h0; m_valid = 1'b0; m_pc4 = m_pc + 32'd4;
      end else if (!v.ih) begin
         m_instr = v.imem; m_valid = 1'b1; m_pc4 = m_pc + 32'd4;
      end
      m_pc  = npc;
      m_epc = nepc;
   endtask

   task automatic check_state(input string tag, input logic [31:0] pc, pc4, instr,
                              input logic valid, input logic [31:0] epc);
      chk({tag, ".pc"},    IMem_Addr,          pc);
      chk({tag, ".pc4"},   ID_PC_Plus4,        pc4);
      chk({tag, ".instr"}, ID_Instr,           instr);
      chk({tag, ".valid"}, {31'd0, ID_Valid},  {31'd0, valid});
      chk({tag, ".epc"},   EPC,                epc);
   endtask

   initial begin
      vec_t v;
      tbl[0]  = mk(0,0,0,3'd0,0,0,0,0,0,0,32'hA000_0000, 0,32'h8000_0004,32'h8000_0004,32'hA000_0000,1,32'h0);
      tbl[1]  = mk(0,0,0,3'd0,0,0,0,0,0,0,32'hA000_0001, 0,32'h8000_0008,32'h8000_0008,32'hA000_0001,1,32'h0);
      tbl[2]  = mk(0,0,1,3'd2,32'h0000_0010,0,0,0,0,0,32'hA000_0002, 0,32'h0000_0010,32'h8000_000C,32'h0,0,32'h0);
      tbl[3]  = mk(1,1,0,3'd0,0,0,0,0,0,0,32'hB000_0000, 0,32'h0000_0010,32'h8000_000C,32'h0,0,32'h0);
      tbl[4]  = mk(0,0,0,3'd0,0,0,0,0,0,0,32'hB000_0000, 0,32'h0000_0014,32'h0000_0014,32'hB000_0000,1,32'h0);
      tbl[5]  = mk(0,0,0,3'd0,0,0,0,0,0,0,32'hB000_0001, 0,32'h0000_0018,32'h0000_0018,32'hB000_0001,1,32'h0);
      tbl[6]  = mk(0,0,0,3'd0,0,0,0,0,0,0,32'hB000_0002, 0,32'h0000_001C,32'h0000_001C,32'hB000_0002,1,32'h0);
      tbl[7]  = mk(0,0,0,3'd0,0,0,0,0,0,0,32'hB000_0003, 0,32'h0000_0020,32'h0000_0020,32'hB000_0003,1,32'h0);
      tbl[8]  = mk(0,0,1,3'd0,0,0,1,32'h0000_0100,0,1,32'hB000_0004, 0,32'h0000_0100,32'h0000_0024,32'h0,0,32'h0);
      tbl[9]  = mk(0,0,1,3'd0,0,0,0,0,0,1,32'hC000_0000, 1,32'h8000_0008,32'h0000_0104,32'h0,0,32'h0000_0100);
      tbl[10] = mk(0,0,1,3'd3,0,32'h0000_0043,0,0,0,0,32'hC000_0001, 0,32'h0000_0040,32'h8000_000C,32'h0,0,32'h0000_0100);
      tbl[11] = mk(0,0,0,3'd0,0,0,0,0,0,0,32'hD000_0000, 0,32'h0000_0044,32'h0000_0044,32'hD000_0000,1,32'h0000_0100);
      tbl[12] = mk(0,0,1,3'd0,0,0,0,0,1,1,32'hD000_0001, 0,32'h8000_0004,32'h0000_0048,32'h0,0,32'h0000_0044);
      tbl[13] = mk(0,0,0,3'd0,0,0,0,0,0,1,32'hE000_0000, 0,32'h8000_0008,32'h8000_0008,32'hE000_0000,1,32'h0000_0044);
      tbl[14] = mk(0,0,1,3'd3,0,32'h0000_0203,0,0,0,0,32'hE000_0001, 0,32'h0000_0200,32'h8000_000C,32'h0,0,32'h0000_0044);
      tbl[15] = mk(0,1,1,3'd0,0,0,0,0,0,0,32'hF000_0000, 0,32'h0000_0204,32'h0000_0204,32'h0,0,32'h0000_0044);
      tbl[16] = mk(0,0,0,3'd2,32'hFFFF_FFFE,0,0,0,0,0,32'hF000_0001, 0,32'hFFFF_FFFC,32'h0000_0208,32'hF000_0001,1,32'h0000_0044);
      tbl[17] = mk(0,0,0,3'd0,0,0,0,0,0,0,32'hF000_0002, 0,32'h0000_0000,32'h0000_0000,32'hF000_0002,1,32'h0000_0044);
      tbl[18] = mk(1,1,0,3'd0,0,0,1,32'h0000_0300,1,1,32'hF000_0003, 0,32'h0000_0000,32'h0000_0000,32'hF000_0002,1,32'h0000_0044);
      tbl[19] = mk(0,0,1,3'd0,0,0,1,32'h0000_0300,1,1,32'hF000_0004, 0,32'h0000_0300,32'h0000_0004,32'h0,0,32'h0000_0044);

      // Reset state, with Irq raised to confirm it cannot be accepted
      reset = 1'b0;
      drive(mk(0,0,0,3'd0,0,0,0,0,0,1,32'h1234_5678,0,0,0,0,0,0));
      @(posedge clk); @(posedge clk); #1;
      check_state("reset", 32'h8000_0000, 32'h8000_0000, 32'h0, 1'b0, 32'h0);
      chk("reset.irq_take", {31'd0, IRQ_Take}, 32'd0);

      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 20; i++) begin
         drive(tbl[i]);
         #1;
         chk($sformatf("vec%0d.irq_take", i), {31'd0, IRQ_Take}, {31'd0, tbl[i].e_irq});
         @(posedge clk); #1;
         check_state($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_pc4,
                     tbl[i].e_instr, tbl[i].e_valid, tbl[i].e_epc);
         @(negedge clk);
      end

      // Asynchronous reset between edges at PC 0000_0300
      Irq = 1'b1;
      #2 reset = 1'b0;
      #1;
      check_state("async_rst", 32'h8000_0000, 32'h8000_0000, 32'h0, 1'b0, 32'h0);
      chk("async_rst.irq_take", {31'd0, IRQ_Take}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      model_reset();

      // Randomized cycles against the behavioural model
      for (int n = 0; n < 600; n++) begin
         v.ph   = ($urandom_range(0, 9) == 0);
         v.ih   = v.ph ? 1'b1 : ($urandom_range(0, 11) == 0);
         v.fl   = ($urandom_range(0, 3) == 0);
         v.src  = 3'($urandom_range(0, 7));
         v.jt   = {$urandom_range(0, 1) == 0 ? 1'b0 : 1'b1, 31'($urandom)};
         v.jr   = {$urandom_range(0, 2) == 0 ? 1'b1 : 1'b0, 31'($urandom)};
         v.br   = ($urandom_range(0, 7) == 0);
         v.bt   = {1'b0, 31'($urandom)};
         v.und  = ($urandom_range(0, 9) == 0);
         v.irq  = ($urandom_range(0, 1) == 1);
         v.imem = $urandom;
         v.e_irq = 1'b0; v.e_pc = 0; v.e_pc4 = 0; v.e_instr = 0; v.e_valid = 0; v.e_epc = 0;
         drive(v);
         #1;
         chk($sformatf("rnd%0d.irq_take", n), {31'd0, IRQ_Take}, {31'd0, model_irq(v)});
         model_step(v);
         @(posedge clk); #1;
         check_state($sformatf("rnd%0d", n), m_pc, m_pc4, m_instr, m_valid, m_epc);
         @(negedge clk);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the pipelined MIPS CPU: owns the PC register, the IF/ID pipeline register and the EPC register. It consumes the hazard unit's hold/flush signals (PC_Hold, IF_Hold, IF_Flush) and the redirect sources (EX branch, ID jump/jr, exception, interrupt) to sequence fetch. It also produces IRQ_Take, the qualified interrupt request that the hazard unit sees as irq_valid. It sits between instruction memory and the ID stage.

## Interface
- RESET_PC, 32'h8000_0000, PC after reset (kernel space)
- ILLOP_ADDR, 32'h8000_0004, undefined-instruction handler vector
- XADR, 32'h8000_0008, interrupt handler vector
- clk  in  1  system clock, all state rising-edge
- reset  in  1  asynchronous, active-low; one clock domain
- PC_Hold  in  1  freeze PC (load-use stall)
- IF_Hold  in  1  freeze IF/ID register
- IF_Flush  in  1  load bubble into IF/ID
- ID_PCSrc  in  3  PC source decoded in ID: 2 = j/jal, 3 = jr/jalr, others = no ID redirect
- ID_JumpTarget  in  32  {ID_PC_Plus4[31:28], instr[25:0], 2'b00}
- ID_JrTarget  in  32  forwarded rs value
- EX_BranchTaken  in  1  EX_PCSrc==1 && ALUout_0
- EX_BranchTarget  in  32  branch target computed in EX
- Undefine  in  1  ID instruction undecodable
- Irq  in  1  level interrupt request from peripherals
- IMem_Data  in  32  combinational instruction memory read data
- IMem_Addr  out  32  = PC
- IRQ_Take  out  1  interrupt accepted this cycle (to hazard irq_valid)
- ID_Instr  out  32  IF/ID instruction
- ID_PC_Plus4  out  32  IF/ID PC+4
- ID_Valid  out  1  IF/ID holds a real instruction
- EPC  out  32  exception return address

## Operation
- PC+4 is 32-bit wrap-around; PC[1:0] always 0 (targets with nonzero low bits are forced to 00).
- Next-PC priority, highest first:
  1. PC_Hold: PC unchanged.
  2. EX_BranchTaken: EX_BranchTarget.
  3. Undefine: ILLOP_ADDR; EPC <= ID_PC_Plus4, so the handler resumes after the bad instruction.
  4. IRQ_Take: XADR; EPC <= PC, the address of the instruction being flushed from IF.
  5. ID_PCSrc==2: ID_JumpTarget. ID_PCSrc==3: ID_JrTarget.
  6. Otherwise PC+4.
- IRQ_Take = Irq && !PC[31] && !ID_PC_Plus4[31] && !PC_Hold && !EX_BranchTaken && !Undefine && ID_PCSrc∉{2,3}.
  - Combinational.
  - A deferred Irq remains pending as a level; no internal latch.
- Kernel mode is PC[31]=1. No interrupt is accepted in kernel mode; Undefine is still honoured.
- IF/ID register update:
  - IF_Flush (wins over IF_Hold): ID_Instr <= 0 (nop), ID_Valid <= 0, ID_PC_Plus4 <= PC+4.
  - IF_Hold: all fields retain.
  - Otherwise: ID_Instr <= IMem_Data, ID_PC_Plus4 <= PC+4, ID_Valid <= 1.
- EPC changes only on an accepted Undefine or IRQ_Take, and never both in the same cycle (Undefine wins).

## Timing
- Reset values: PC=RESET_PC, ID_Instr=0, ID_PC_Plus4=RESET_PC, ID_Valid=0, EPC=0. IRQ_Take=0 while reset is asserted.
- Reset assertion mid-operation immediately forces these values, with no clock required. Release is synchronous to the next rising edge.
- Redirect latency: a redirect selected in cycle N fetches the target in N+1. The wrong-path instruction fetched in N is killed by the hazard unit's IF_Flush in N.
- Load-use stall: PC_Hold=IF_Hold=1 for exactly one cycle. PC and IF/ID both repeat, and fetch resumes the following cycle.
- IRQ_Take and the resulting hazard IF_Flush occur in the same cycle. The handler's first instruction reaches ID two cycles later.

## Structure
- Shared package `cpu_pkg`: PCSrc encodings (PCSRC_SEQ=0, PCSRC_BR=1, PCSRC_J=2, PCSRC_JR=3), RESET_PC/ILLOP_ADDR/XADR defaults, NOP_INSTR=32'h0.
- One sub-module, `next_pc_sel`: purely combinational priority mux computing next PC, the EPC write enable/value, and IRQ_Take. Registers stay in if_stage.

## Test plan
- Reset, then sequential fetch: release reset → IMem_Addr 8000_0000, 8000_0004, 8000_0008 on successive cycles; ID_Valid rises on the first edge after release.
- Load-use stall: PC=0000_0010 with PC_Hold=IF_Hold=1 for one cycle → IMem_Addr stays 0000_0010 for two cycles; ID_Instr unchanged across the stall.
- Branch taken vs pending Irq: EX_BranchTaken=1, target 0000_0100, Irq=1, PC=0000_0020 → next PC 0000_0100, IRQ_Take=0. The following cycle IRQ_Take=1, EPC=0000_0100, next PC 8000_0008.
- Undefine at user PC: ID_PC_Plus4=0000_0044, Undefine=1 → next PC 8000_0004, EPC=0000_0044. Irq=1 in kernel space → IRQ_Take stays 0.
- jr redirect with flush: ID_PCSrc=3, ID_JrTarget=0000_0203 → next PC 0000_0200; IF_Flush loads ID_Instr=0, ID_Valid=0.
- Asynchronous reset mid-run: PC=0000_0300, reset asserted between clock edges → PC=8000_0000 and EPC=0 immediately.
